// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_access_pkg;

  // Access FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Load funct3 as produced by the control unit
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store size as produced by the control unit; load funct3[1:0] uses the same code
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte enables for an access of the given size starting at the given lane
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_access_unit_load_extend.sv
// Selects the addressed byte/half from a memory word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever the inputs are.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension chosen by load type
  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'h000000, byte_sel};
      F3_LHU:  result_o = {16'h0000, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit: drives a word-addressed memory via req/ack with byte enables.
// Latency: BUSYWAIT high for 2 + (REQ cycles without ack); READ_DATA valid in DONE.
// Backpressure: MEM_REQ held until MEM_ACK; pipeline stalled via BUSYWAIT meanwhile.
module data_mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            MAIN_MEM_READ,
  input  logic [2:0]            MAIN_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSYWAIT,
  output logic                  ACCESS_FAULT,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_WDATA,
  output logic [3:0]            MEM_BE,
  input  logic [31:0]           MEM_RDATA,
  input  logic                  MEM_ACK
);

  state_e                state_q;
  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            be_q;
  logic [31:0]           rdata_q;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic                  is_load_q;

  logic        load_en;
  logic        store_en;
  logic [1:0]  lane;
  logic [1:0]  acc_size;
  logic        illegal;
  logic        misalign;
  logic        fault;
  logic        req_valid;
  logic        in_idle;
  logic [31:0] st_data;
  logic [31:0] ext_data;

  assign load_en  = MAIN_MEM_READ[3];
  // A load takes priority when both enables are raised
  assign store_en = MAIN_MEM_WRITE[2] & ~load_en;
  assign lane     = ADDRESS[1:0];
  assign acc_size = load_en ? MAIN_MEM_READ[1:0] : MAIN_MEM_WRITE[1:0];
  assign in_idle  = (state_q == ST_IDLE);

  // Decode illegal encodings and misalignment for the presented access
  always_comb begin
    illegal = 1'b0;
    if (load_en) begin
      illegal = (MAIN_MEM_READ[2:0] == 3'b011) || (MAIN_MEM_READ[2:0] == 3'b110) ||
                (MAIN_MEM_READ[2:0] == 3'b111);
    end else if (store_en) begin
      illegal = (MAIN_MEM_WRITE[1:0] == SZ_ILL);
    end
    misalign = ((acc_size == SZ_HALF) && lane[0]) ||
               ((acc_size == SZ_WORD) && (lane != 2'b00));
    fault     = (load_en | store_en) & (illegal | misalign);
    req_valid = (load_en | store_en) & ~fault;
  end

  // Place right-aligned store data onto its byte lanes, unused lanes zero
  always_comb begin
    st_data = 32'h0;
    case (MAIN_MEM_WRITE[1:0])
      SZ_BYTE: st_data = {24'h000000, WRITE_DATA[7:0]} << {lane, 3'b000};
      SZ_HALF: st_data = lane[1] ? {WRITE_DATA[15:0], 16'h0000} : {16'h0000, WRITE_DATA[15:0]};
      default: st_data = WRITE_DATA;
    endcase
  end

  load_extend u_load_extend (
    .rdata_i  (MEM_RDATA),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .result_o (ext_data)
  );

  // Stall and fault flags are combinational so the pipeline sees them in the accept cycle
  assign BUSYWAIT     = RESET & ((in_idle & req_valid) | (state_q == ST_REQ));
  assign ACCESS_FAULT = RESET & in_idle & fault;

  // Access FSM with registered memory-side outputs and load result
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      rdata_q   <= 32'h0;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      is_load_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q   <= ST_REQ;
            req_q     <= 1'b1;
            we_q      <= store_en;
            addr_q    <= {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
            wdata_q   <= store_en ? st_data : 32'h0;
            be_q      <= lane_be(acc_size, lane);
            f3_q      <= MAIN_MEM_READ[2:0];
            lane_q    <= lane;
            is_load_q <= load_en;
          end
        end
        ST_REQ: begin
          if (MEM_ACK) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            be_q    <= 4'h0;
            if (is_load_q) begin
              rdata_q <= ext_data;
            end
          end
        end
        // The pipeline advances on this edge; the still-presented request is not re-accepted
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign READ_DATA = rdata_q;
  assign MEM_REQ   = req_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_BE    = be_q;

endmodule
